// File: rtl/cand_scan_ctrl_pkg.sv
// Shared definitions for the candidate scan controller: default board
// dimensions, derived index widths and the controller state encoding.
package cand_scan_ctrl_pkg;

    // Default board geometry.
    localparam int DEF_NUM_ROWS = 19;
    localparam int DEF_NUM_COLS = 14;

    // Derived widths: row index, encoder output, candidate counter.
    // The counter must hold DEF_NUM_ROWS * DEF_NUM_COLS (266).
    localparam int DEF_ROW_W = 5;
    localparam int DEF_COL_W = 4;
    localparam int DEF_CNT_W = 9;

    // Controller state encoding.
    localparam int          STATE_W  = 3;
    localparam logic [2:0]  ST_IDLE  = 3'd0;
    localparam logic [2:0]  ST_FETCH = 3'd1;
    localparam logic [2:0]  ST_LOAD  = 3'd2;
    localparam logic [2:0]  ST_SCAN  = 3'd3;
    localparam logic [2:0]  ST_DONE  = 3'd4;

endpackage

// File: rtl/cand_scan_ctrl_pri.sv
// Leftmost-first priority encoder. Element 0 is the leftmost position and
// wins over every higher index. With no element set the index reads 0 and
// active is low; callers must qualify the index with active.
module code_pri #(
    parameter int num_elements = 14,
    parameter int idx_w        = 4
) (
    input  logic [0:num_elements-1] elements,
    output logic [idx_w-1:0]        leftmost_element,
    output logic                    active
);

    // Walk from the rightmost element down so the lowest set index is the
    // last one written and therefore the one that sticks.
    always_comb begin
        leftmost_element = '0;
        active           = |elements;
        for (int i = num_elements - 1; i >= 0; i--) begin
            if (elements[i]) begin
                leftmost_element = idx_w'(i);
            end
        end
    end

endmodule

// File: rtl/cand_scan_ctrl.sv
// Candidate scan controller: walks every row of the candidate-mask memory,
// streams each set bit as a (row, col) candidate leftmost column first over
// a valid/ready interface, and pulses done once the board is exhausted.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// FETCH | read strobe issued for the current row
// LOAD  | row mask captured from the memory read data
// SCAN  | present candidates until the mask is empty, then next row
// DONE  | one-cycle done pulse, back to IDLE
module cand_scan_ctrl
    import cand_scan_ctrl_pkg::*;
#(
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int NUM_COLS = DEF_NUM_COLS,
    parameter int ROW_W    = DEF_ROW_W,
    parameter int COL_W    = DEF_COL_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                row_rd,
    output logic [ROW_W-1:0]    row_addr,
    input  logic [0:NUM_COLS-1] row_data,
    output logic                cand_valid,
    input  logic                cand_ready,
    output logic [ROW_W-1:0]    cand_row,
    output logic [COL_W-1:0]    cand_col,
    output logic [CNT_W-1:0]    cand_count
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [STATE_W-1:0]  state;
    logic [ROW_W-1:0]    row_idx;
    logic [0:NUM_COLS-1] mask;
    logic [CNT_W-1:0]    count_q;
    logic [COL_W-1:0]    lead_col;
    logic                mask_active;
    logic                accept;

    code_pri #(
        .num_elements (NUM_COLS),
        .idx_w        (COL_W)
    ) u_pri (
        .elements         (mask),
        .leftmost_element (lead_col),
        .active           (mask_active)
    );

    // Output decode: everything is derived from state and the live mask so a
    // stalled candidate cannot change until the mask itself changes.
    always_comb begin
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        row_rd     = (state == ST_FETCH);
        row_addr   = row_idx;
        cand_valid = (state == ST_SCAN) && mask_active;
        cand_row   = row_idx;
        cand_col   = lead_col;
        cand_count = count_q;
        accept     = cand_valid && cand_ready;
    end

    // Sequencer: row walk, mask capture and clear-on-accept, candidate count.
    // Abort outranks an accept in the same cycle, so an aborted candidate
    // is neither cleared nor counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            row_idx <= '0;
            mask    <= '0;
            count_q <= '0;
        end else if ((state != ST_IDLE) && abort) begin
            state <= ST_IDLE;
            mask  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state   <= ST_FETCH;
                        row_idx <= '0;
                        count_q <= '0;
                    end
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    mask  <= row_data;
                    state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (mask_active) begin
                        if (accept) begin
                            mask[lead_col] <= 1'b0;
                            if (count_q != CNT_MAX) begin
                                count_q <= count_q + CNT_W'(1);
                            end
                        end
                    end else if (row_idx == LAST_ROW) begin
                        state <= ST_DONE;
                    end else begin
                        row_idx <= row_idx + ROW_W'(1);
                        state   <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cand_scan_ctrl.sv
// Directed bench for cand_scan_ctrl: a table of single-row boards with
// ready patterns and hand-computed done cycles, plus sequences for abort,
// start/abort interaction and mid-pass reset.
module tb_cand_scan_ctrl;

    localparam int NR = 19;
    localparam int NC = 14;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int KW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          row_rd;
    logic [RW-1:0] row_addr;
    logic [0:NC-1] row_data;
    logic          cand_valid;
    logic          cand_ready;
    logic [RW-1:0] cand_row;
    logic [CW-1:0] cand_col;
    logic [KW-1:0] cand_count;

    always #5 clk = ~clk;

    cand_scan_ctrl #(
        .NUM_ROWS (NR),
        .NUM_COLS (NC),
        .ROW_W    (RW),
        .COL_W    (CW),
        .CNT_W    (KW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .row_rd     (row_rd),
        .row_addr   (row_addr),
        .row_data   (row_data),
        .cand_valid (cand_valid),
        .cand_ready (cand_ready),
        .cand_row   (cand_row),
        .cand_col   (cand_col),
        .cand_count (cand_count)
    );

    // Mask memory model: data valid the cycle after the read strobe, random
    // junk otherwise so any out-of-LOAD sampling corrupts the scan.
    logic [0:NC-1] board [0:NR-1];
    logic          rd_q;
    logic [RW-1:0] addr_q;
    logic [0:NC-1] junk;

    always @(posedge clk) begin
        rd_q   <= row_rd;
        addr_q <= row_addr;
        junk   <= NC'($urandom);
    end

    assign row_data = rd_q ? board[addr_q] : junk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_board(input int r, input logic [0:NC-1] m);
        for (int i = 0; i < NR; i++) board[i] = '0;
        board[r] = m;
    endtask

    typedef struct {
        int            row;
        logic [0:NC-1] mask;
        logic [7:0]    pat;        // ready pattern, bit i used on the i-th valid cycle
        int            plen;
        int            exp_count;
        int            exp_done;   // cycle n = period after edge n-1, start at edge 0
        bit            inj;        // pulse start mid-pass (must be ignored)
    } vec_t;

    vec_t vecs [6];

    task automatic run_pass(input vec_t v, input string tag);
        int  er[$];
        int  ec[$];
        int  cyc;
        int  pidx;
        int  done_cyc;
        bit  prev_stall;
        int  prow;
        int  pcol;
        set_board(v.row, v.mask);
        for (int c = 0; c < NC; c++) begin
            if (v.mask[c]) begin
                er.push_back(v.row);
                ec.push_back(c);
            end
        end
        abort      = 1'b0;
        cand_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        cyc        = 1;
        pidx       = 0;
        done_cyc   = -1;
        prev_stall = 1'b0;
        prow       = 0;
        pcol       = 0;
        while (cyc <= 300) begin
            start = v.inj && (cyc == 4);
            if (prev_stall) begin
                chk({tag, "_stall_valid"}, int'(cand_valid), 1);
                chk({tag, "_stall_row"}, int'(cand_row), prow);
                chk({tag, "_stall_col"}, int'(cand_col), pcol);
            end
            if (cand_valid) begin
                cand_ready = v.pat[pidx % v.plen];
                pidx++;
                if (cand_ready) begin
                    if (er.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL %s_extra_cand actual=(%0d,%0d) expected=none",
                                 tag, cand_row, cand_col);
                    end else begin
                        chk({tag, "_cand_row"}, int'(cand_row), er.pop_front());
                        chk({tag, "_cand_col"}, int'(cand_col), ec.pop_front());
                    end
                end
                prev_stall = !cand_ready;
                prow       = int'(cand_row);
                pcol       = int'(cand_col);
            end else begin
                cand_ready = 1'b1;
                prev_stall = 1'b0;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start      = 1'b0;
        cand_ready = 1'b1;
        chk({tag, "_done_cycle"}, done_cyc, v.exp_done);
        chk({tag, "_count"}, int'(cand_count), v.exp_count);
        chk({tag, "_missing_cands"}, er.size(), 0);
        @(negedge clk);
        chk({tag, "_busy_after_done"}, int'(busy), 0);
        chk({tag, "_done_one_cycle"}, int'(done), 0);
        chk({tag, "_count_hold"}, int'(cand_count), v.exp_count);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int dcount;
        bit found;

        vecs[0] = '{row: 0,  mask: 14'b00000000000000, pat: 8'b1,  plen: 1,
                    exp_count: 0,  exp_done: 58, inj: 1'b0};
        vecs[1] = '{row: 3,  mask: 14'b10000100000001, pat: 8'b1,  plen: 1,
                    exp_count: 3,  exp_done: 61, inj: 1'b1};
        vecs[2] = '{row: 3,  mask: 14'b10000100000001, pat: 8'b001, plen: 3,
                    exp_count: 3,  exp_done: 65, inj: 1'b0};
        vecs[3] = '{row: 18, mask: 14'b11111111111111, pat: 8'b1,  plen: 1,
                    exp_count: 14, exp_done: 72, inj: 1'b0};
        vecs[4] = '{row: 0,  mask: 14'b00000000000001, pat: 8'b1,  plen: 1,
                    exp_count: 1,  exp_done: 59, inj: 1'b0};
        vecs[5] = '{row: 18, mask: 14'b11111111111111, pat: 8'b01, plen: 2,
                    exp_count: 14, exp_done: 85, inj: 1'b0};

        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        cand_ready = 1'b1;
        set_board(0, '0);
        repeat (3) @(negedge clk);
        chk("reset_ctrl", int'({busy, done, row_rd, cand_valid}), 0);
        chk("reset_data", int'({row_addr, cand_row, cand_col, cand_count}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            run_pass(vecs[i], $sformatf("vec%0d", i));
        end

        // start and abort together in IDLE must not launch a pass.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle_busy", int'(busy), 0);
        chk("start_abort_idle_rd", int'(row_rd), 0);
        @(negedge clk);
        chk("start_abort_idle_busy2", int'(busy), 0);

        // Abort on the second candidate of row 3; a start pulse at cycle 5
        // must not restart the pass.
        set_board(3, 14'b10000100000001);
        cand_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        found = 1'b0;
        while (cyc <= 100 && !found) begin
            start = (cyc == 5);
            if (cand_valid && cand_col == 4'd5) begin
                found = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk("abort_second_cand_cycle", cyc, 13);
        chk("abort_second_cand_row", int'(cand_row), 3);
        chk("abort_count_before", int'(cand_count), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid_low", int'(cand_valid), 0);
        chk("abort_busy_low", int'(busy), 0);
        chk("abort_count_partial", int'(cand_count), 1);
        dcount = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        chk("abort_count_hold", int'(cand_count), 1);

        // Reset in the middle of row 18's scan.
        set_board(18, 14'b11111111111111);
        cand_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc <= 100 && !cand_valid) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_first_valid_cycle", cyc, 57);
        repeat (3) @(negedge clk);
        chk("rst_pre_col", int'(cand_col), 3);
        chk("rst_pre_count", int'(cand_count), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ctrl", int'({busy, done, row_rd, cand_valid}), 0);
        chk("rst_mid_data", int'({row_addr, cand_row, cand_col, cand_count}), 0);
        @(negedge clk);
        chk("rst_mid_stay_idle", int'(busy), 0);
        run_pass(vecs[2], "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cand_scan_ctrl.md
Name: cand_scan_ctrl

Overview:
- Sequences the leftmost-first priority encoder across a whole board.
- Fetches one row mask at a time from the candidate-mask memory and emits every set position as a (row, col) candidate, leftmost column first, over a valid/ready stream.
- Clears each served bit and advances rows until the board is exhausted, then pulses done.
- Sits between the candidate-mask store and the move-evaluation pipeline.

Parameters:
- NUM_ROWS, 19, rows scanned per pass.
- NUM_COLS, 14, bits per row mask and encoder width; must be 16 or less.
- ROW_W, 5, row index width.
- COL_W, 4, column index width; matches the encoder output.
- CNT_W, 9, candidate counter width; must hold NUM_ROWS*NUM_COLS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a pass; honoured only in IDLE.
- abort  in  1  terminate a pass; honoured in any non-IDLE state.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a completed pass.
- row_rd  out  1  read strobe to the mask memory.
- row_addr  out  ROW_W  row being read; valid with row_rd.
- row_data  in  [0:NUM_COLS-1]  row mask; valid the cycle after row_rd. Bit 0 is the leftmost column.
- cand_valid  out  1  candidate available.
- cand_ready  in  1  consumer accepts.
- cand_row  out  ROW_W  candidate row.
- cand_col  out  COL_W  candidate column, the lowest set index of the current mask.
- cand_count  out  CNT_W  candidates accepted in the current or last pass.

Behaviour:
- Reset values: state IDLE; busy, done, row_rd, cand_valid = 0; row_addr, cand_row, cand_col, cand_count = 0; internal mask = 0.
- IDLE: start=1 -> FETCH with row index 0, cand_count cleared to 0. start and abort in the same cycle -> stay IDLE.
- FETCH, 1 cycle: row_rd=1, row_addr=row index -> LOAD.
- LOAD, 1 cycle: mask <= row_data -> SCAN.
- SCAN:
  - mask != 0: cand_valid=1, cand_row=row index, cand_col=encoder(mask).
  - On cand_valid & cand_ready: clear that bit of mask and increment cand_count, all in the same edge. Stay in SCAN.
  - mask == 0, last row: -> DONE.
  - mask == 0, not last row: row index + 1, -> FETCH.
  - The encoder output is never used when mask == 0; cand_valid stays 0.
- DONE, 1 cycle: done=1 -> IDLE. cand_count holds its value until the next start.
- Handshake rules:
  - While cand_valid=1 and cand_ready=0, cand_row and cand_col stay stable.
  - cand_valid never drops without a handshake, except on abort or rst.
- Latency: start sampled at edge 0, cand_ready held 1. done is high during cycle 1 + 3*NUM_ROWS + K, where K is the total set bits on the board. Each row costs FETCH + LOAD + one cycle per set bit + one empty-mask SCAN cycle.
- Throughput: one candidate per cycle within a row when ready is held high.
- abort in a non-IDLE state -> IDLE at the next edge. No done pulse; cand_valid=0 from the next cycle; cand_count keeps its partial value.
- start while busy is ignored.
- rst mid-pass -> all reset values; no done pulse.
- cand_count saturates at all-ones. It cannot overflow with legal parameters.
- row_data is sampled only in LOAD and ignored at all other times.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, FETCH, LOAD, SCAN, DONE);
  - the default board dimensions NUM_ROWS and NUM_COLS;
  - the derived widths ROW_W, COL_W, CNT_W.
- One sub-module is natural: the existing code_pri priority encoder, instantiated with num_elements=NUM_COLS on the mask register.
  - Its leftmost_element output drives cand_col.
  - Its active output gates cand_valid and the SCAN exit decision.

Test Plan:
- Empty board (all rows 0), ready=1, start at cycle 0 -> no cand_valid; done in cycle 58; cand_count=0; busy falls the cycle after done.
- Row 3 = bits 0, 5, 13 set, all other rows 0, ready=1 -> candidates (3,0), (3,5), (3,13) on consecutive cycles; done in cycle 61; cand_count=3.
- Same board, cand_ready toggled 1,0,0,1,... -> cand_row and cand_col stable during stalls; same 3 candidates in order; done delayed by exactly the stall count.
- Row 18 = all 14 bits set -> cols 0..13 in ascending order with row 18; cand_count=14; done in cycle 72.
- abort asserted in the cycle the second candidate of row 3 is presented -> cand_valid=0 next cycle; IDLE; no done; cand_count=1. Also: start during busy is ignored, and start+abort in IDLE stays IDLE.
- rst asserted mid-SCAN -> all outputs at reset values the next cycle. A following start runs a full, correct pass from row 0.
